// File: rtl/first_nios2_system_timer_pkg.sv
// Register map, control bits and sequencer states shared by the
// interval-timer tick scheduler and its deadline channels.
package first_nios2_system_timer_pkg;

  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_PERIODL = 3'd2;
  localparam logic [2:0] REG_PERIODH = 3'd3;

  localparam logic [15:0] CTRL_ITO   = 16'h0001;
  localparam logic [15:0] CTRL_CONT  = 16'h0002;
  localparam logic [15:0] CTRL_START = 16'h0004;
  localparam logic [15:0] CTRL_STOP  = 16'h0008;

  typedef enum logic [3:0] {
    IDLE,
    WR_PL,
    WR_PH,
    WR_CTRL,
    RUN,
    ACK,
    SVC,
    WR_STOP,
    CLR
  } sched_state_t;

endpackage

// File: rtl/first_nios2_system_timer_chan.sv
// One one-shot deadline counter: loads on arm, counts down once per serviced
// tick and pulses expire on the 1->0 step. An arm in the same cycle wins.
module first_nios2_system_timer_chan #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_tick,
  input  logic             i_arm,
  input  logic [CNT_W-1:0] i_arm_ticks,
  output logic             o_expire,
  output logic             o_armed
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_armed;
  logic             w_last;

  assign w_last   = (r_cnt == CNT_W'(1));
  assign o_expire = i_tick && r_armed && !i_arm && w_last;
  assign o_armed  = r_armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_armed <= 1'b0;
    end else if (i_arm) begin
      // A zero load is a cancel: disarm silently.
      r_cnt   <= i_arm_ticks;
      r_armed <= (i_arm_ticks != '0);
    end else if (i_tick && r_armed) begin
      r_cnt <= r_cnt - 1'b1;
      if (w_last) begin
        r_armed <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/first_nios2_system_timer_sched.sv
// Sole Avalon-MM master of the interval timer: programs and runs it, acks each
// timeout and fans every tick out to N_CH one-shot deadline channels.
module first_nios2_system_timer_sched
  import first_nios2_system_timer_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16,
  parameter int CH_W  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [31:0]      cmd_period,
  input  logic             arm_valid,
  input  logic [CH_W-1:0]  arm_ch,
  input  logic [CNT_W-1:0] arm_ticks,
  output logic [N_CH-1:0]  expire,
  output logic [N_CH-1:0]  armed,
  output logic             running,
  output logic [31:0]      tick_count,
  output logic [2:0]       tmr_address,
  output logic             tmr_chipselect,
  output logic             tmr_write_n,
  output logic [15:0]      tmr_writedata,
  input  logic             tmr_irq
);

  sched_state_t r_state;
  sched_state_t w_state_next;
  logic [31:0]  r_period;
  logic [31:0]  r_tick_count;
  logic         r_running;
  logic         w_accept;
  logic         w_tick;
  logic [N_CH-1:0] w_arm;

  assign w_accept   = cmd_valid && cmd_ready;
  assign w_tick     = (r_state == SVC);
  assign running    = r_running;
  assign tick_count = r_tick_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_period     <= '0;
      r_running    <= 1'b0;
      r_tick_count <= '0;
    end else begin
      if (w_accept && !cmd_op) begin
        r_period <= cmd_period;
      end
      if (r_state == WR_CTRL) begin
        r_running    <= 1'b1;
        r_tick_count <= '0;
      end else if (r_state == SVC) begin
        r_tick_count <= r_tick_count + 32'd1;
      end
      if (r_state == CLR) begin
        r_running <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    cmd_ready      = 1'b0;
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_address    = REG_STATUS;
    tmr_writedata  = '0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && !cmd_op) begin
          w_state_next = WR_PL;
        end
      end
      WR_PL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = REG_PERIODL;
        tmr_writedata  = r_period[15:0];
        w_state_next   = WR_PH;
      end
      WR_PH: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = REG_PERIODH;
        tmr_writedata  = r_period[31:16];
        w_state_next   = WR_CTRL;
      end
      WR_CTRL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = REG_CONTROL;
        tmr_writedata  = CTRL_ITO | CTRL_CONT | CTRL_START;
        w_state_next   = RUN;
      end
      RUN: begin
        // A pending timeout is serviced before any command is taken.
        if (tmr_irq) begin
          w_state_next = ACK;
        end else begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            w_state_next = cmd_op ? WR_STOP : WR_PL;
          end
        end
      end
      ACK: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        w_state_next   = SVC;
      end
      SVC: begin
        w_state_next = RUN;
      end
      WR_STOP: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = REG_CONTROL;
        tmr_writedata  = CTRL_STOP;
        w_state_next   = CLR;
      end
      CLR: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        w_state_next   = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign w_arm[gi] = arm_valid && (arm_ch == CH_W'(gi));
      first_nios2_system_timer_chan #(
        .CNT_W(CNT_W)
      ) u_chan (
        .clk        (clk),
        .reset      (reset),
        .i_tick     (w_tick),
        .i_arm      (w_arm[gi]),
        .i_arm_ticks(arm_ticks),
        .o_expire   (expire[gi]),
        .o_armed    (armed[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_first_nios2_system_timer_sched.sv
// Bench for the timer tick scheduler: timer writes are scoreboarded against
// expected (address, data, cycle) entries; deadlines are checked per tick.
module tb_first_nios2_system_timer_sched;

  localparam int N_CH  = 4;
  localparam int CNT_W = 16;
  localparam int CH_W  = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_op = 1'b0;
  logic [31:0]      cmd_period = '0;
  logic             arm_valid = 1'b0;
  logic [CH_W-1:0]  arm_ch = '0;
  logic [CNT_W-1:0] arm_ticks = '0;
  logic [N_CH-1:0]  expire;
  logic [N_CH-1:0]  armed;
  logic             running;
  logic [31:0]      tick_count;
  logic [2:0]       tmr_address;
  logic             tmr_chipselect;
  logic             tmr_write_n;
  logic [15:0]      tmr_writedata;
  logic             tmr_irq = 1'b0;

  always #5 clk = ~clk;

  first_nios2_system_timer_sched #(
    .N_CH (N_CH),
    .CNT_W(CNT_W),
    .CH_W (CH_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_period    (cmd_period),
    .arm_valid     (arm_valid),
    .arm_ch        (arm_ch),
    .arm_ticks     (arm_ticks),
    .expire        (expire),
    .armed         (armed),
    .running       (running),
    .tick_count    (tick_count),
    .tmr_address   (tmr_address),
    .tmr_chipselect(tmr_chipselect),
    .tmr_write_n   (tmr_write_n),
    .tmr_writedata (tmr_writedata),
    .tmr_irq       (tmr_irq)
  );

  typedef struct {
    logic [2:0]  a;
    logic [15:0] d;
    int          c;
  } wr_t;

  wr_t         exp_q[$];
  int          cyc = 0;
  int          obs_n = 0;
  logic [2:0]  obs_a[1024];
  logic [15:0] obs_d[1024];
  int          obs_c[1024];
  int          rd_idx = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_ticks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: records every timer write with the cycle it occurred in.
  always @(negedge clk) begin
    if (tmr_chipselect && !tmr_write_n && obs_n < 1024) begin
      obs_a[obs_n] <= tmr_address;
      obs_d[obs_n] <= tmr_writedata;
      obs_c[obs_n] <= cyc;
      obs_n        <= obs_n + 1;
      $display("[%0t] cyc %0d timer write addr=%0d data=0x%04h", $time, cyc, tmr_address, tmr_writedata);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic op, input logic [31:0] period, output int c_acc);
    bit done = 1'b0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_period = period;
    c_acc = -1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        c_acc = cyc;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL cmd_accept: got no cmd_ready in 20 cycles, want acceptance");
    end else begin
      $display("[%0t] cmd op=%0d period=0x%08h accepted in cyc %0d", $time, op, period, c_acc);
    end
  endtask

  task automatic arm(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] t);
    arm_valid = 1'b1;
    arm_ch = ch;
    arm_ticks = t;
    step(1);
    arm_valid = 1'b0;
    $display("[%0t] arm ch%0d ticks=%0d", $time, ch, t);
  endtask

  // One irq pulse from RUN; optional arm during SVC; returns expire seen in SVC.
  task automatic do_tick(input logic sv_arm, input logic [CH_W-1:0] ch,
                         input logic [CNT_W-1:0] t, output logic [N_CH-1:0] ev);
    tmr_irq = 1'b1;
    step(1);
    tmr_irq = 1'b0;
    step(1);
    arm_valid = sv_arm;
    arm_ch = ch;
    arm_ticks = t;
    @(negedge clk);
    ev = expire;
    @(posedge clk);
    #1;
    arm_valid = 1'b0;
    exp_ticks++;
    $display("[%0t] tick %0d expire=%b", $time, exp_ticks, ev);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {1'b0, 1'b1, 3'd0, 16'h0000}) begin
      n_err++;
      $display("FAIL reset_bus: got cs=%b wn=%b addr=%0d data=0x%04h, want cs=0 wn=1 addr=0 data=0x0000",
               tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
    end
    n_cmp++;
    if ({running, tick_count, expire, armed} !== {1'b0, 32'd0, 4'b0000, 4'b0000}) begin
      n_err++;
      $display("FAIL reset_state: got running=%b ticks=%0d expire=%b armed=%b, want 0 0 0000 0000",
               running, tick_count, expire, armed);
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %b, want 1", cmd_ready);
    end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_start();
    int c;
    int base;
    wr_t e;
    base = obs_n;
    rd_idx = obs_n;
    send_cmd(1'b0, 32'h0001_86A0, c);
    exp_q.push_back('{3'd2, 16'h86A0, c + 1});
    exp_q.push_back('{3'd3, 16'h0001, c + 2});
    exp_q.push_back('{3'd1, 16'h0007, c + 3});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (cmd_ready !== 1'b0) begin
        n_err++;
        $display("FAIL start_ready_low[%0d]: got %b, want 0", k, cmd_ready);
      end
      step(1);
    end
    @(negedge clk);
    n_cmp++;
    if ({running, tick_count, cmd_ready} !== {1'b1, 32'd0, 1'b1}) begin
      n_err++;
      $display("FAIL start_run: got running=%b ticks=%0d ready=%b, want 1 0 1", running, tick_count, cmd_ready);
    end
    step(1);
    exp_ticks = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rd_idx >= obs_n || obs_a[rd_idx] !== e.a || obs_d[rd_idx] !== e.d || obs_c[rd_idx] != e.c) begin
        n_err++;
        $display("FAIL start_wr: got addr=%0d data=0x%04h cyc=%0d, want addr=%0d data=0x%04h cyc=%0d",
                 obs_a[rd_idx], obs_d[rd_idx], obs_c[rd_idx], e.a, e.d, e.c);
      end
      rd_idx++;
    end
    n_cmp++;
    if (obs_n != rd_idx) begin
      n_err++;
      $display("FAIL start_wr_count: got %0d writes, want %0d", obs_n - base, rd_idx - base);
    end
  endtask

  task automatic test_tick();
    int c;
    int base;
    wr_t e;
    base = obs_n;
    rd_idx = obs_n;
    c = cyc;
    tmr_irq = 1'b1;
    exp_q.push_back('{3'd0, 16'h0000, c + 1});
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL tick_irq_priority: got ready=%b, want 0", cmd_ready);
    end
    step(1);
    tmr_irq = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({cmd_ready, tick_count} !== {1'b0, 32'd0}) begin
        n_err++;
        $display("FAIL tick_busy[%0d]: got ready=%b ticks=%0d, want 0 0", k, cmd_ready, tick_count);
      end
      step(1);
    end
    exp_ticks++;
    @(negedge clk);
    n_cmp++;
    if ({cmd_ready, tick_count} !== {1'b1, 32'd1}) begin
      n_err++;
      $display("FAIL tick_done: got ready=%b ticks=%0d, want 1 1", cmd_ready, tick_count);
    end
    step(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rd_idx >= obs_n || obs_a[rd_idx] !== e.a || obs_d[rd_idx] !== e.d || obs_c[rd_idx] != e.c) begin
        n_err++;
        $display("FAIL tick_ack_wr: got addr=%0d data=0x%04h cyc=%0d, want addr=%0d data=0x%04h cyc=%0d",
                 obs_a[rd_idx], obs_d[rd_idx], obs_c[rd_idx], e.a, e.d, e.c);
      end
      rd_idx++;
    end
    n_cmp++;
    if (obs_n != rd_idx) begin
      n_err++;
      $display("FAIL tick_wr_count: got %0d writes, want %0d", obs_n - base, rd_idx - base);
    end
  endtask

  task automatic test_expire();
    logic [N_CH-1:0] ev;
    logic [N_CH-1:0] want;
    arm(2'd0, 16'd1);
    arm(2'd2, 16'd3);
    @(negedge clk);
    n_cmp++;
    if (armed !== 4'b0101) begin
      n_err++;
      $display("FAIL expire_armed: got %b, want 0101", armed);
    end
    step(1);
    for (int k = 1; k <= 3; k++) begin
      do_tick(1'b0, '0, '0, ev);
      want = (k == 1) ? 4'b0001 : (k == 3) ? 4'b0100 : 4'b0000;
      n_cmp++;
      if (ev !== want) begin
        n_err++;
        $display("FAIL expire_tick%0d: got %b, want %b", k, ev, want);
      end
      @(negedge clk);
      n_cmp++;
      if (expire !== 4'b0000) begin
        n_err++;
        $display("FAIL expire_width%0d: got %b after SVC, want 0000", k, expire);
      end
      step(1);
    end
    @(negedge clk);
    n_cmp++;
    if ({armed, tick_count} !== {4'b0000, 32'(exp_ticks)}) begin
      n_err++;
      $display("FAIL expire_after: got armed=%b ticks=%0d, want 0000 %0d", armed, tick_count, exp_ticks);
    end
    step(1);
  endtask

  task automatic test_arm_in_svc();
    logic [N_CH-1:0] ev;
    logic [N_CH-1:0] want;
    arm(2'd1, 16'd1);
    arm(2'd2, 16'd1);
    do_tick(1'b1, 2'd1, 16'd5, ev);
    n_cmp++;
    if (ev !== 4'b0100) begin
      n_err++;
      $display("FAIL svc_arm_tick: got %b, want 0100", ev);
    end
    @(negedge clk);
    n_cmp++;
    if (armed !== 4'b0010) begin
      n_err++;
      $display("FAIL svc_arm_armed: got %b, want 0010", armed);
    end
    step(1);
    for (int k = 1; k <= 5; k++) begin
      do_tick(1'b0, '0, '0, ev);
      want = (k == 5) ? 4'b0010 : 4'b0000;
      n_cmp++;
      if (ev !== want) begin
        n_err++;
        $display("FAIL svc_arm_count%0d: got %b, want %b", k, ev, want);
      end
    end
  endtask

  task automatic test_cancel();
    logic [N_CH-1:0] ev;
    arm(2'd3, 16'd3);
    do_tick(1'b0, '0, '0, ev);
    arm(2'd3, 16'd0);
    @(negedge clk);
    n_cmp++;
    if ({armed, expire} !== {4'b0000, 4'b0000}) begin
      n_err++;
      $display("FAIL cancel_armed: got armed=%b expire=%b, want 0000 0000", armed, expire);
    end
    step(1);
    for (int k = 1; k <= 3; k++) begin
      do_tick(1'b0, '0, '0, ev);
      n_cmp++;
      if (ev !== 4'b0000) begin
        n_err++;
        $display("FAIL cancel_tick%0d: got %b, want 0000", k, ev);
      end
    end
  endtask

  task automatic test_stop();
    int c;
    int base;
    wr_t e;
    arm(2'd0, 16'd7);
    base = obs_n;
    rd_idx = obs_n;
    send_cmd(1'b1, 32'd0, c);
    exp_q.push_back('{3'd1, 16'h0008, c + 1});
    exp_q.push_back('{3'd0, 16'h0000, c + 2});
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({cmd_ready, running} !== 2'b01) begin
        n_err++;
        $display("FAIL stop_busy[%0d]: got ready=%b running=%b, want 0 1", k, cmd_ready, running);
      end
      step(1);
    end
    @(negedge clk);
    n_cmp++;
    if ({cmd_ready, running, armed, tick_count} !== {1'b1, 1'b0, 4'b0001, 32'(exp_ticks)}) begin
      n_err++;
      $display("FAIL stop_idle: got ready=%b running=%b armed=%b ticks=%0d, want 1 0 0001 %0d",
               cmd_ready, running, armed, tick_count, exp_ticks);
    end
    step(1);
    send_cmd(1'b1, 32'd0, c);
    step(3);
    @(negedge clk);
    n_cmp++;
    if ({cmd_ready, running} !== 2'b10) begin
      n_err++;
      $display("FAIL stop_in_idle: got ready=%b running=%b, want 1 0", cmd_ready, running);
    end
    step(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rd_idx >= obs_n || obs_a[rd_idx] !== e.a || obs_d[rd_idx] !== e.d || obs_c[rd_idx] != e.c) begin
        n_err++;
        $display("FAIL stop_wr: got addr=%0d data=0x%04h cyc=%0d, want addr=%0d data=0x%04h cyc=%0d",
                 obs_a[rd_idx], obs_d[rd_idx], obs_c[rd_idx], e.a, e.d, e.c);
      end
      rd_idx++;
    end
    n_cmp++;
    if (obs_n != rd_idx) begin
      n_err++;
      $display("FAIL stop_wr_count: got %0d writes, want %0d", obs_n - base, rd_idx - base);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    int base;
    wr_t e;
    base = obs_n;
    rd_idx = obs_n;
    send_cmd(1'b0, 32'h0000_0010, c);
    exp_q.push_back('{3'd2, 16'h0010, c + 1});
    exp_q.push_back('{3'd3, 16'h0000, c + 2});
    exp_q.push_back('{3'd1, 16'h0007, c + 3});
    step(3);
    exp_ticks = 0;
    send_cmd(1'b0, 32'h0002_0003, c);
    exp_q.push_back('{3'd2, 16'h0003, c + 1});
    exp_q.push_back('{3'd3, 16'h0002, c + 2});
    exp_q.push_back('{3'd1, 16'h0007, c + 3});
    @(negedge clk);
    n_cmp++;
    if ({running, cmd_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL restart_running: got running=%b ready=%b, want 1 0", running, cmd_ready);
    end
    step(3);
    c = cyc;
    tmr_irq = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL irq_stop_priority: got ready=%b, want 0", cmd_ready);
    end
    step(1);
    tmr_irq = 1'b0;
    step(3);
    cmd_valid = 1'b0;
    exp_ticks++;
    $display("[%0t] irq+STOP sequence issued in cyc %0d", $time, c);
    exp_q.push_back('{3'd0, 16'h0000, c + 1});
    exp_q.push_back('{3'd1, 16'h0008, c + 4});
    exp_q.push_back('{3'd0, 16'h0000, c + 5});
    step(2);
    @(negedge clk);
    n_cmp++;
    if ({running, cmd_ready, tick_count} !== {1'b0, 1'b1, 32'(exp_ticks)}) begin
      n_err++;
      $display("FAIL irq_stop_idle: got running=%b ready=%b ticks=%0d, want 0 1 %0d",
               running, cmd_ready, tick_count, exp_ticks);
    end
    step(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rd_idx >= obs_n || obs_a[rd_idx] !== e.a || obs_d[rd_idx] !== e.d || obs_c[rd_idx] != e.c) begin
        n_err++;
        $display("FAIL b2b_wr: got addr=%0d data=0x%04h cyc=%0d, want addr=%0d data=0x%04h cyc=%0d",
                 obs_a[rd_idx], obs_d[rd_idx], obs_c[rd_idx], e.a, e.d, e.c);
      end
      rd_idx++;
    end
    n_cmp++;
    if (obs_n != rd_idx) begin
      n_err++;
      $display("FAIL b2b_wr_count: got %0d writes, want %0d", obs_n - base, rd_idx - base);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    int base;
    wr_t e;
    base = obs_n;
    rd_idx = obs_n;
    send_cmd(1'b0, 32'hABCD_1234, c);
    exp_q.push_back('{3'd2, 16'h1234, c + 1});
    exp_q.push_back('{3'd3, 16'hABCD, c + 2});
    step(1);
    @(negedge clk);
    reset = 1'b1;
    step(1);
    @(negedge clk);
    n_cmp++;
    if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {1'b0, 1'b1, 3'd0, 16'h0000}) begin
      n_err++;
      $display("FAIL mid_reset_bus: got cs=%b wn=%b addr=%0d data=0x%04h, want cs=0 wn=1 addr=0 data=0x0000",
               tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
    end
    n_cmp++;
    if ({running, tick_count, expire, armed, cmd_ready} !== {1'b0, 32'd0, 4'b0000, 4'b0000, 1'b1}) begin
      n_err++;
      $display("FAIL mid_reset_state: got running=%b ticks=%0d expire=%b armed=%b ready=%b, want 0 0 0000 0000 1",
               running, tick_count, expire, armed, cmd_ready);
    end
    reset = 1'b0;
    step(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rd_idx >= obs_n || obs_a[rd_idx] !== e.a || obs_d[rd_idx] !== e.d || obs_c[rd_idx] != e.c) begin
        n_err++;
        $display("FAIL mid_reset_wr: got addr=%0d data=0x%04h cyc=%0d, want addr=%0d data=0x%04h cyc=%0d",
                 obs_a[rd_idx], obs_d[rd_idx], obs_c[rd_idx], e.a, e.d, e.c);
      end
      rd_idx++;
    end
    n_cmp++;
    if (obs_n != rd_idx) begin
      n_err++;
      $display("FAIL mid_reset_wr_count: got %0d writes, want %0d", obs_n - base, rd_idx - base);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_tick();
    test_expire();
    test_arm_in_svc();
    test_cancel();
    test_stop();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, want bench to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
